// File: rtl/gcc_pkg.sv
// rtl/gcc_pkg.sv - shared state type and default sizing for the coincidence counter
package gcc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_COINC_WIN   = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rising and any-edge pulse detection
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic any_edge
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise     = sync_q[STAGES-1] & ~prev_q;
  assign any_edge = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/gated_coincidence_counter.sv
// rtl/gated_coincidence_counter.sv - gated singles/coincidence counter with valid/ready snapshot
module gated_coincidence_counter
  import gcc_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int COINC_WIN   = DEF_COINC_WIN
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             gate_toggle,
  input  logic             det_a,
  input  logic             det_b,
  output logic [CNT_W-1:0] counts_a,
  output logic [CNT_W-1:0] counts_b,
  output logic [CNT_W-1:0] counts_coinc,
  output logic             counts_valid,
  input  logic             counts_ready,
  output logic             saturated,
  output logic             overrun
);

  localparam int WIN_W = $clog2(COINC_WIN + 1);

  logic ev_a, ev_b, bnd;
  logic a_any, b_any, g_rise;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk(sys_clk), .rst(reset), .din(det_a), .rise(ev_a), .any_edge(a_any));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk(sys_clk), .rst(reset), .din(det_b), .rise(ev_b), .any_edge(b_any));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_g (
    .clk(sys_clk), .rst(reset), .din(gate_toggle), .rise(g_rise), .any_edge(bnd));

  assign unused_edges = ^{a_any, b_any, g_rise};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d, acc_c_q, acc_c_d;
  logic [CNT_W-1:0]   snap_a_q, snap_a_d, snap_b_q, snap_b_d, snap_c_q, snap_c_d;
  logic [WIN_W-1:0]   win_a_q, win_a_d, win_b_q, win_b_d;
  logic               sat_win_q, sat_win_d;
  logic               valid_q, valid_d, sat_q, sat_d, ovr_q, ovr_d;

  logic               ev_a_c, ev_b_c, coinc, clip_a, clip_b, clip_c, load, xfer;
  logic [CNT_W-1:0]   sum_a, sum_b, sum_c;
  logic [WIN_W-1:0]   win_a_dec, win_b_dec;

  always_comb begin
    state_d   = state_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    acc_c_d   = acc_c_q;
    snap_a_d  = snap_a_q;
    snap_b_d  = snap_b_q;
    snap_c_d  = snap_c_q;
    sat_win_d = sat_win_q;

    ev_a_c = ev_a & (state_q == COUNT);
    ev_b_c = ev_b & (state_q == COUNT);
    coinc  = (ev_a_c & ev_b_c) | (ev_b_c & (|win_a_q)) | (ev_a_c & (|win_b_q));

    // Timers keep running across boundaries so a straddling pair lands in the new window.
    win_a_dec = (win_a_q != '0) ? win_a_q - 1'b1 : win_a_q;
    win_b_dec = (win_b_q != '0) ? win_b_q - 1'b1 : win_b_q;
    if (coinc) begin
      win_a_d = '0;
      win_b_d = '0;
    end else begin
      win_a_d = ev_a_c ? WIN_W'(COINC_WIN) : win_a_dec;
      win_b_d = ev_b_c ? WIN_W'(COINC_WIN) : win_b_dec;
    end

    clip_a = ev_a_c & (&acc_a_q);
    clip_b = ev_b_c & (&acc_b_q);
    clip_c = coinc  & (&acc_c_q);
    sum_a  = clip_a ? acc_a_q : acc_a_q + CNT_W'(ev_a_c);
    sum_b  = clip_b ? acc_b_q : acc_b_q + CNT_W'(ev_b_c);
    sum_c  = clip_c ? acc_c_q : acc_c_q + CNT_W'(coinc);

    load = (state_q == COUNT) & bnd;
    xfer = valid_q & counts_ready;

    if (state_q == IDLE) begin
      if (bnd) begin
        acc_a_d   = '0;
        acc_b_d   = '0;
        acc_c_d   = '0;
        sat_win_d = 1'b0;
        state_d   = COUNT;
      end
    end else if (bnd) begin
      snap_a_d  = sum_a;
      snap_b_d  = sum_b;
      snap_c_d  = sum_c;
      acc_a_d   = '0;
      acc_b_d   = '0;
      acc_c_d   = '0;
      sat_win_d = 1'b0;
    end else begin
      acc_a_d   = sum_a;
      acc_b_d   = sum_b;
      acc_c_d   = sum_c;
      sat_win_d = sat_win_q | clip_a | clip_b | clip_c;
    end

    valid_d = load | (valid_q & ~counts_ready);
    sat_d   = load ? (sat_win_q | clip_a | clip_b | clip_c) : (sat_q & ~xfer);
    ovr_d   = load ? (valid_q & ~counts_ready) : (ovr_q & ~xfer);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      acc_c_q   <= '0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      snap_c_q  <= '0;
      win_a_q   <= '0;
      win_b_q   <= '0;
      sat_win_q <= 1'b0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      acc_c_q   <= acc_c_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      snap_c_q  <= snap_c_d;
      win_a_q   <= win_a_d;
      win_b_q   <= win_b_d;
      sat_win_q <= sat_win_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      ovr_q     <= ovr_d;
    end
  end

  assign counts_a     = snap_a_q;
  assign counts_b     = snap_b_q;
  assign counts_coinc = snap_c_q;
  assign counts_valid = valid_q;
  assign saturated    = sat_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_gated_coincidence_counter.sv
// tb/tb_gated_coincidence_counter.sv - directed self-checking bench for gated_coincidence_counter
module tb_gated_coincidence_counter;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        gate_toggle = 1'b0;
  logic        det_a = 1'b0;
  logic        det_b = 1'b0;
  logic        counts_ready = 1'b0;

  logic [15:0] counts_a, counts_b, counts_coinc;
  logic        counts_valid, saturated, overrun;
  logic [3:0]  counts4_a, counts4_b, counts4_coinc;
  logic        counts4_valid, saturated4, overrun4;

  int n_checks = 0;
  int n_pass = 0;

  always #5 sys_clk = ~sys_clk;

  gated_coincidence_counter dut (
    .sys_clk(sys_clk), .reset(reset), .gate_toggle(gate_toggle),
    .det_a(det_a), .det_b(det_b),
    .counts_a(counts_a), .counts_b(counts_b), .counts_coinc(counts_coinc),
    .counts_valid(counts_valid), .counts_ready(counts_ready),
    .saturated(saturated), .overrun(overrun));

  gated_coincidence_counter #(.CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .reset(reset), .gate_toggle(gate_toggle),
    .det_a(det_a), .det_b(det_b),
    .counts_a(counts4_a), .counts_b(counts4_b), .counts_coinc(counts4_coinc),
    .counts_valid(counts4_valid), .counts_ready(counts_ready),
    .saturated(saturated4), .overrun(overrun4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_a();
    det_a = 1'b1; tick(2); det_a = 1'b0; tick(10);
  endtask

  task automatic pulse_b();
    det_b = 1'b1; tick(2); det_b = 1'b0; tick(10);
  endtask

  // det_b rises d cycles after det_a; both pulses are 2 cycles wide
  task automatic pair(input int d);
    det_a = 1'b1;
    if (d == 0) det_b = 1'b1;
    for (int i = 1; i <= d + 2; i++) begin
      tick(1);
      if (i == 2) det_a = 1'b0;
      if (i == d) det_b = 1'b1;
    end
    det_b = 1'b0;
    tick(15);
  endtask

  task automatic toggle_gate();
    gate_toggle = ~gate_toggle;
    tick(5);
  endtask

  task automatic accept();
    counts_ready = 1'b1; tick(1); counts_ready = 1'b0;
  endtask

  task automatic close_window(input string tag, input int ea, input int eb, input int ec);
    toggle_gate();
    check({tag, "_valid"}, counts_valid, 1);
    check({tag, "_a"}, counts_a, ea);
    check({tag, "_b"}, counts_b, eb);
    check({tag, "_coinc"}, counts_coinc, ec);
    check({tag, "_ovr"}, overrun, 0);
    accept();
    check({tag, "_valid_after_xfer"}, counts_valid, 0);
  endtask

  initial begin
    tick(2);
    check("rst_valid", counts_valid, 0);
    check("rst_a", counts_a, 0);
    check("rst_sat", saturated, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick(2);

    // partial first window: events ignored, boundary gives no snapshot
    pulse_a(); pulse_a();
    toggle_gate();
    check("first_bnd_no_valid", counts_valid, 0);

    repeat (5) pulse_a();
    repeat (3) pulse_b();
    close_window("singles", 5, 3, 0);

    pair(3);
    close_window("coinc_d3", 1, 1, 1);
    pair(5);
    close_window("coinc_d5", 1, 1, 0);
    pair(0);
    close_window("coinc_d0", 1, 1, 1);

    // overrun: two boundaries without ready
    pulse_a();
    toggle_gate();
    check("ovr_first_valid", counts_valid, 1);
    check("ovr_first_a", counts_a, 1);
    pulse_a(); pulse_a();
    toggle_gate();
    check("ovr_valid", counts_valid, 1);
    check("ovr_a", counts_a, 2);
    check("ovr_flag", overrun, 1);
    accept();
    check("ovr_valid_cleared", counts_valid, 0);
    check("ovr_flag_cleared", overrun, 0);

    // saturation only on the 4-bit instance
    repeat (20) pulse_a();
    toggle_gate();
    check("sat16_a", counts_a, 20);
    check("sat16_flag", saturated, 0);
    check("sat4_a", counts4_a, 15);
    check("sat4_flag", saturated4, 1);
    check("sat4_valid", counts4_valid, 1);
    accept();
    check("sat4_flag_cleared", saturated4, 0);

    // boundary coincident with ready: old accepted, new loaded
    pulse_b();
    toggle_gate();
    check("bndrdy_first_b", counts_b, 1);
    pulse_b(); pulse_b();
    gate_toggle = ~gate_toggle;
    tick(2);
    counts_ready = 1'b1;
    tick(1);
    counts_ready = 1'b0;
    check("bndrdy_valid", counts_valid, 1);
    check("bndrdy_b", counts_b, 2);
    check("bndrdy_ovr", overrun, 0);

    // reset mid-window with a pending snapshot and 7 accumulated events
    repeat (7) pulse_a();
    reset = 1'b1;
    #1;
    check("midrst_valid", counts_valid, 0);
    check("midrst_b", counts_b, 0);
    check("midrst_a", counts_a, 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    toggle_gate();
    check("post_rst_bnd_no_valid", counts_valid, 0);
    pulse_a();
    close_window("post_rst", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gated_coincidence_counter.md
Name: gated_coincidence_counter

Overview:
- Sits directly downstream of the 1 Hz gate timer and consumes its gate_toggle output; every toggle edge closes one counting window and opens the next.
- Counts rising edges on two asynchronous detector inputs (singles A, singles B) and A/B coincidences within a programmable cycle window.
- At each window boundary it snapshots the three counts and presents them on a valid/ready interface to the display/readout stage.

Parameters:
- CNT_W, 16, width of each count, saturating.
- SYNC_STAGES, 2, flop depth of each input synchronizer (minimum 2).
- COINC_WIN, 4, coincidence window in sys_clk cycles (minimum 1).

Ports:
- sys_clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- gate_toggle  in  1  timer toggle (async-safe); each edge is a window boundary.
- det_a  in  1  detector A pulse, asynchronous, at least 1 sys_clk wide.
- det_b  in  1  detector B pulse, asynchronous, at least 1 sys_clk wide.
- counts_a  out  CNT_W  singles A for the last closed window.
- counts_b  out  CNT_W  singles B for the last closed window.
- counts_coinc  out  CNT_W  coincidences for the last closed window.
- counts_valid  out  1  snapshot available.
- counts_ready  in  1  consumer accepts the snapshot.
- saturated  out  1  at least one snapshot count clipped at all-ones.
- overrun  out  1  an unaccepted snapshot was overwritten.

Behaviour:
- Reset: all outputs 0, accumulators 0, coincidence timers 0, state IDLE. Synchronizers and edge-detect history are cleared to 0.
- Inputs: det_a, det_b and gate_toggle each pass through SYNC_STAGES flops.
  - ev_a / ev_b: one-cycle rising-edge pulses from the synchronized detector inputs.
  - bnd: a pulse on either edge of the synchronized toggle.
  - Latency from a det pin edge to the accumulator increment is SYNC_STAGES+1 cycles.
- FSM:
  - IDLE: events are ignored. On bnd, clear accumulators and go to COUNT. No snapshot is taken because the first window is partial.
  - COUNT: accumulate. On bnd:
    - load snapshot registers with accumulator values that include same-cycle events;
    - clear accumulators to 0;
    - set counts_valid;
    - remain in COUNT.
- Singles: acc_a += ev_a and acc_b += ev_b. Each accumulator saturates at 2^CNT_W-1 and does not wrap. A per-window sat flag is set on any clipped increment.
- Coincidence:
  - ev_a loads timer win_a = COINC_WIN; ev_b loads win_b likewise. Timers decrement to 0.
  - A coincidence is counted if any of these holds:
    - ev_a and ev_b arrive in the same cycle;
    - ev_b arrives while win_a > 0;
    - ev_a arrives while win_b > 0.
  - Each coincidence clears both timers, so an event pairs at most once.
  - acc_coinc saturates like the singles accumulators.
  - Coincidence timers are not cleared at bnd, so a pair straddling a boundary is counted in the new window.
- Handshake:
  - Transfer occurs when counts_valid && counts_ready. counts_valid drops the next cycle unless a new snapshot loads in the same cycle.
  - counts_* and saturated are stable while counts_valid is 1 and no bnd occurs.
  - bnd while valid and not ready: overwrite the snapshot, keep valid, set overrun.
  - bnd together with ready: the old snapshot is accepted, the new one loads, valid stays 1, overrun is 0.
  - overrun and saturated reflect the current snapshot and clear on its transfer.
- Reset mid-window or mid-handshake: immediate return to the reset state. The pending snapshot is lost.

Decomposition:
- Shared package gcc_pkg:
  - state enum {IDLE, COUNT};
  - default CNT_W and COINC_WIN constants, reused by the timer and display blocks.
- One sub-module, sync_edge:
  - SYNC_STAGES synchronizer plus edge detector, with outputs rise and any_edge.
  - Instantiated three times: det_a, det_b, gate_toggle.

Test Plan:
- Reset, then toggle gate_toggle every 1000 cycles, with 5 det_a and 3 det_b pulses spaced more than 10 cycles apart -> the first window yields no snapshot; the second gives counts_a=5, counts_b=3, counts_coinc=0, valid=1.
- det_b rising 3 cycles after det_a, COINC_WIN=4 -> coinc=1; det_b at 5 cycles -> coinc=0; both rising in the same cycle -> coinc=1. Singles count every edge.
- Hold counts_ready=0 across two boundaries -> the second snapshot replaces the first, overrun=1, valid=1. Then ready=1 for 1 cycle -> valid=0, overrun=0.
- CNT_W=4 with 20 det_a pulses in one window -> counts_a=15, saturated=1, no wrap.
- bnd in the same cycle as counts_ready=1 -> valid stays 1, new counts are presented, overrun=0.
- Assert reset mid-window with 7 accumulated events -> all outputs 0 immediately. After release the next bnd produces no snapshot, returning to IDLE behaviour.
